// File: rtl/wb_arbiter_rr_if.sv
// rtl/wb_arbiter_rr_if.sv - bus bundle for the two-master round-robin Wishbone arbiter
interface wb_arbiter_rr_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_a_cyc;
    logic          i_a_stb;
    logic          i_a_we;
    logic [AW-1:0] i_a_addr;
    logic [DW-1:0] i_a_data;
    logic          o_a_ack;
    logic          o_a_stall;
    logic          o_a_err;
    logic [DW-1:0] o_a_data;

    logic          i_b_cyc;
    logic          i_b_stb;
    logic          i_b_we;
    logic [AW-1:0] i_b_addr;
    logic [DW-1:0] i_b_data;
    logic          o_b_ack;
    logic          o_b_stall;
    logic          o_b_err;
    logic [DW-1:0] o_b_data;

    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic          i_wb_ack;
    logic          i_wb_stall;
    logic          i_wb_err;
    logic [DW-1:0] i_wb_data;

    logic [1:0]    o_owner;

    // Arbiter side: it is the slave of both bus masters.
    modport slave (
        input  i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        output o_a_ack, o_a_stall, o_a_err, o_a_data,
        input  i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        output o_b_ack, o_b_stall, o_b_err, o_b_data,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
        output o_owner
    );

    modport master (
        output i_a_cyc, i_a_stb, i_a_we, i_a_addr, i_a_data,
        input  o_a_ack, o_a_stall, o_a_err, o_a_data,
        output i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data,
        input  o_b_ack, o_b_stall, o_b_err, o_b_data,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data,
        input  o_owner
    );
endinterface

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - two-master pipelined Wishbone arbiter, round-robin with stall watchdog
module wb_arbiter_rr #(
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_arbiter_rr_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        OWN_A,
        OWN_B,
        ABORT_A,
        ABORT_B
    } state_t;

    state_t        state;
    logic          last_b;
    logic [TW-1:0] timer;
    logic [1:0]    owner;

    logic own_a;
    logic own_b;
    logic cur_cyc;
    logic cur_stb;
    logic accept;
    logic timeout;

    always_comb begin
        own_a   = (state == OWN_A);
        own_b   = (state == OWN_B);
        cur_cyc = (own_a & bus.i_a_cyc) | (own_b & bus.i_b_cyc);
        cur_stb = (own_a & bus.i_a_stb) | (own_b & bus.i_b_stb);
        accept  = cur_stb & ~bus.i_wb_stall;
        // A response arriving on the expiry cycle rescues the transaction.
        timeout = cur_cyc & (timer == TW'(TIMEOUT)) & ~bus.i_wb_ack & ~bus.i_wb_err;
    end

    always_comb begin
        bus.o_wb_cyc  = cur_cyc & ~timeout;
        bus.o_wb_stb  = cur_stb & ~timeout;
        bus.o_wb_we   = (own_a & bus.i_a_we) | (own_b & bus.i_b_we);
        bus.o_wb_addr = own_a ? bus.i_a_addr : (own_b ? bus.i_b_addr : '0);
        bus.o_wb_data = own_a ? bus.i_a_data : (own_b ? bus.i_b_data : '0);

        bus.o_a_stall = own_a ? bus.i_wb_stall : 1'b1;
        bus.o_a_ack   = own_a & bus.i_wb_ack;
        bus.o_a_err   = own_a & (bus.i_wb_err | timeout);
        bus.o_a_data  = bus.i_wb_data;

        bus.o_b_stall = own_b ? bus.i_wb_stall : 1'b1;
        bus.o_b_ack   = own_b & bus.i_wb_ack;
        bus.o_b_err   = own_b & (bus.i_wb_err | timeout);
        bus.o_b_data  = bus.i_wb_data;

        bus.o_owner   = owner;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            last_b <= 1'b1;
            timer  <= '0;
            owner  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    // last only moves on a contested grant
                    if (bus.i_a_cyc && bus.i_b_cyc) begin
                        if (last_b) begin
                            state  <= OWN_A;
                            owner  <= 2'b01;
                            last_b <= 1'b0;
                        end else begin
                            state  <= OWN_B;
                            owner  <= 2'b10;
                            last_b <= 1'b1;
                        end
                    end else if (bus.i_a_cyc) begin
                        state <= OWN_A;
                        owner <= 2'b01;
                    end else if (bus.i_b_cyc) begin
                        state <= OWN_B;
                        owner <= 2'b10;
                    end
                end
                OWN_A, OWN_B: begin
                    if (!cur_cyc) begin
                        state <= IDLE;
                        owner <= 2'b00;
                        timer <= '0;
                    end else if (timeout) begin
                        state <= own_a ? ABORT_A : ABORT_B;
                        timer <= '0;
                    end else if (accept || bus.i_wb_ack || bus.i_wb_err) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ABORT_A: begin
                    if (!bus.i_a_cyc) begin
                        state <= IDLE;
                        owner <= 2'b00;
                    end
                end
                ABORT_B: begin
                    if (!bus.i_b_cyc) begin
                        state <= IDLE;
                        owner <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'b00;
                    timer <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed scoreboard bench for wb_arbiter_rr
module tb_wb_arbiter_rr;
    logic clk;
    logic rst_n;

    wb_arbiter_rr_if #(.AW(32), .DW(32)) bus ();

    wb_arbiter_rr #(.TIMEOUT(8)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memdev-style slave: one-cycle ack for every accepted strobe
    logic [31:0] mem [32];
    logic        ack_q;
    logic [31:0] rdat;
    logic        slave_en;
    logic        force_ack;

    assign bus.i_wb_ack  = ack_q | force_ack;
    assign bus.i_wb_data = rdat;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 ^ (i * 32'h0101);
    end

    always @(posedge clk) begin
        ack_q <= slave_en & bus.o_wb_cyc & bus.o_wb_stb & ~bus.i_wb_stall;
        rdat  <= mem[bus.o_wb_addr[4:0]];
        if (bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall && bus.o_wb_we)
            mem[bus.o_wb_addr[4:0]] <= bus.o_wb_data;
    end

    int checks = 0;
    int errors = 0;
    int acks   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] rd_exp [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic b_beat(input logic stb, input logic [31:0] addr, input logic stall);
        logic [31:0] exp;
        drive_edge();
        bus.i_a_cyc    = 1'b1;
        bus.i_b_stb    = stb;
        bus.i_b_addr   = addr;
        bus.i_wb_stall = stall;
        sample();
        chk("t3_owner_b", {30'd0, bus.o_owner}, 32'd2);
        chk("t3_b_stall_mirror", {31'd0, bus.o_b_stall}, {31'd0, stall});
        chk("t3_a_waits", {31'd0, bus.o_a_stall}, 32'd1);
        if (bus.o_b_ack) begin
            acks++;
            chk("t3_ack_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                chk("t3_b_rd_data", bus.o_b_data, exp);
            end
        end
        if (bus.o_wb_cyc && bus.o_wb_stb && !bus.i_wb_stall)
            exp_q.push_back(rd_exp[addr[1:0]]);
    endtask

    initial begin
        rd_exp = '{32'h5A00_0000, 32'h5A00_0101, 32'h5A00_0202, 32'h5A00_0303};
        rst_n = 1'b0;
        slave_en = 1'b1;
        force_ack = 1'b0;
        bus.i_a_cyc = 0; bus.i_a_stb = 0; bus.i_a_we = 0; bus.i_a_addr = 0; bus.i_a_data = 0;
        bus.i_b_cyc = 0; bus.i_b_stb = 0; bus.i_b_we = 0; bus.i_b_addr = 0; bus.i_b_data = 0;
        bus.i_wb_stall = 0; bus.i_wb_err = 0;

        sample();
        chk("rst_owner", {30'd0, bus.o_owner}, 32'd0);
        chk("rst_a_stall", {31'd0, bus.o_a_stall}, 32'd1);
        chk("rst_b_stall", {31'd0, bus.o_b_stall}, 32'd1);
        chk("rst_wb_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("rst_wb_stb", {31'd0, bus.o_wb_stb}, 32'd0);
        chk("rst_a_ack", {31'd0, bus.o_a_ack}, 32'd0);
        drive_edge();
        drive_edge();
        rst_n = 1'b1;

        // A single write
        bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_we = 1;
        bus.i_a_addr = 32'h10; bus.i_a_data = 32'hDEAD_BEEF;
        sample();
        chk("t1_idle_owner", {30'd0, bus.o_owner}, 32'd0);
        chk("t1_idle_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        drive_edge(); sample();
        chk("t1_owner_a", {30'd0, bus.o_owner}, 32'd1);
        chk("t1_wb_stb", {31'd0, bus.o_wb_stb}, 32'd1);
        chk("t1_wb_we", {31'd0, bus.o_wb_we}, 32'd1);
        chk("t1_wb_addr", bus.o_wb_addr, 32'h10);
        chk("t1_wb_data", bus.o_wb_data, 32'hDEAD_BEEF);
        chk("t1_a_stall", {31'd0, bus.o_a_stall}, 32'd0);
        chk("t1_b_stall", {31'd0, bus.o_b_stall}, 32'd1);
        drive_edge(); bus.i_a_stb = 0; sample();
        chk("t1_a_ack", {31'd0, bus.o_a_ack}, 32'd1);
        chk("t1_b_ack", {31'd0, bus.o_b_ack}, 32'd0);
        drive_edge(); bus.i_a_cyc = 0; bus.i_a_we = 0; sample();
        chk("t1_release_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);

        // simultaneous requests, round-robin
        drive_edge(); bus.i_a_cyc = 1; bus.i_b_cyc = 1; sample();
        chk("t2_idle", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t2_first_a", {30'd0, bus.o_owner}, 32'd1);
        chk("t2_b_stall", {31'd0, bus.o_b_stall}, 32'd1);
        drive_edge(); bus.i_a_cyc = 0; sample();
        chk("t2_a_drop_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        drive_edge(); sample();
        chk("t2_dead_cycle", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t2_then_b", {30'd0, bus.o_owner}, 32'd2);
        drive_edge(); bus.i_b_cyc = 0; sample();
        drive_edge(); bus.i_a_cyc = 1; bus.i_b_cyc = 1; sample();
        chk("t2_idle2", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t2_rr_b", {30'd0, bus.o_owner}, 32'd2);
        drive_edge(); bus.i_b_cyc = 0; sample();
        drive_edge(); sample();
        chk("t2_dead2", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t2_rr_a", {30'd0, bus.o_owner}, 32'd1);
        drive_edge(); bus.i_a_cyc = 0; sample();
        drive_edge(); bus.i_b_cyc = 1; sample();
        chk("t3_idle", {30'd0, bus.o_owner}, 32'd0);

        // B 4-beat pipelined read with a stall on beat 2, A waiting
        b_beat(1, 0, 0);
        b_beat(1, 1, 1);
        b_beat(1, 1, 0);
        b_beat(1, 2, 0);
        b_beat(1, 3, 0);
        b_beat(0, 0, 0);
        b_beat(0, 0, 0);
        chk("t3_ack_count", acks, 32'd4);
        chk("t3_queue_empty", exp_q.size(), 32'd0);
        drive_edge(); bus.i_b_cyc = 0; sample();
        chk("t3_b_drop_owner", {30'd0, bus.o_owner}, 32'd2);
        chk("t3_b_drop_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        drive_edge(); sample();
        chk("t3_dead", {30'd0, bus.o_owner}, 32'd0);

        // watchdog: slave never acks
        drive_edge();
        bus.i_a_stb = 1; bus.i_a_we = 0; bus.i_a_addr = 5; slave_en = 0;
        sample();
        chk("t4_owner_a", {30'd0, bus.o_owner}, 32'd1);
        chk("t4_a_stall", {31'd0, bus.o_a_stall}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            drive_edge(); bus.i_a_stb = 0; bus.i_b_cyc = 1; sample();
            chk("t4_no_err_early", {31'd0, bus.o_a_err}, 32'd0);
            chk("t4_cyc_held", {31'd0, bus.o_wb_cyc}, 32'd1);
        end
        drive_edge(); sample();
        chk("t4_err_pulse", {31'd0, bus.o_a_err}, 32'd1);
        chk("t4_err_cyc_low", {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("t4_err_stb_low", {31'd0, bus.o_wb_stb}, 32'd0);
        chk("t4_b_no_err", {31'd0, bus.o_b_err}, 32'd0);
        drive_edge(); sample();
        chk("t4_abort_owner", {30'd0, bus.o_owner}, 32'd1);
        chk("t4_abort_err_gone", {31'd0, bus.o_a_err}, 32'd0);
        chk("t4_abort_stall", {31'd0, bus.o_a_stall}, 32'd1);
        chk("t4_abort_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("t4_abort_b_stall", {31'd0, bus.o_b_stall}, 32'd1);
        drive_edge(); bus.i_a_cyc = 0; sample();
        chk("t4_abort_hold", {30'd0, bus.o_owner}, 32'd1);
        drive_edge(); sample();
        chk("t4_idle", {30'd0, bus.o_owner}, 32'd0);

        // ack lands on the timeout cycle
        drive_edge(); bus.i_b_stb = 1; bus.i_b_we = 0; bus.i_b_addr = 2; sample();
        chk("t5_owner_b", {30'd0, bus.o_owner}, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            drive_edge(); bus.i_b_stb = 0; sample();
            chk("t5_no_err_early", {31'd0, bus.o_b_err}, 32'd0);
        end
        drive_edge(); force_ack = 1; sample();
        chk("t5_ack_wins", {31'd0, bus.o_b_ack}, 32'd1);
        chk("t5_no_err", {31'd0, bus.o_b_err}, 32'd0);
        chk("t5_cyc_kept", {31'd0, bus.o_wb_cyc}, 32'd1);
        drive_edge(); force_ack = 0; sample();
        chk("t5_after_no_err", {31'd0, bus.o_b_err}, 32'd0);
        chk("t5_still_owner", {30'd0, bus.o_owner}, 32'd2);
        chk("t5_still_cyc", {31'd0, bus.o_wb_cyc}, 32'd1);
        drive_edge(); bus.i_b_cyc = 0; slave_en = 1; sample();

        // asynchronous reset mid-transfer
        drive_edge();
        bus.i_a_cyc = 1; bus.i_a_stb = 1; bus.i_a_we = 1; bus.i_a_addr = 7; bus.i_a_data = 32'h1234_5678;
        sample();
        chk("t6_idle", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t6_owner_a", {30'd0, bus.o_owner}, 32'd1);
        chk("t6_stb", {31'd0, bus.o_wb_stb}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_owner", {30'd0, bus.o_owner}, 32'd0);
        chk("t6_rst_cyc", {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("t6_rst_stb", {31'd0, bus.o_wb_stb}, 32'd0);
        chk("t6_rst_a_stall", {31'd0, bus.o_a_stall}, 32'd1);
        chk("t6_rst_b_stall", {31'd0, bus.o_b_stall}, 32'd1);
        chk("t6_rst_a_ack", {31'd0, bus.o_a_ack}, 32'd0);
        chk("t6_rst_a_err", {31'd0, bus.o_a_err}, 32'd0);
        bus.i_a_stb = 0; bus.i_a_we = 0; bus.i_b_cyc = 1;
        drive_edge(); sample();
        chk("t6_rst_hold", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); rst_n = 1'b1; sample();
        chk("t6_post_idle", {30'd0, bus.o_owner}, 32'd0);
        drive_edge(); sample();
        chk("t6_regrant_a", {30'd0, bus.o_owner}, 32'd1);
        drive_edge(); bus.i_a_cyc = 0; bus.i_b_cyc = 0;
        drive_edge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Two-master, one-slave Wishbone (pipelined) arbiter with round-robin fairness.
- Lets the DEPP bridge (master A) and an on-chip engine such as a DWT/DMA sequencer (master B) share one memdev-style slave.
- Grant is held for the whole bus cycle (CYC high).
- A watchdog aborts cycles that stall without completing and returns ERR to the owning master.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, idle cycles allowed under an owned cycle before abort; must be ≥2

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A Wishbone controls
- i_a_addr  in  AW  master A address
- i_a_data  in  DW  master A write data
- o_a_ack, o_a_stall, o_a_err  out  1 each  master A responses
- o_a_data  out  DW  master A read data
- i_b_cyc, i_b_stb, i_b_we  in  1 each  master B Wishbone controls
- i_b_addr  in  AW  master B address
- i_b_data  in  DW  master B write data
- o_b_ack, o_b_stall, o_b_err  out  1 each  master B responses
- o_b_data  out  DW  master B read data
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave-side controls
- o_wb_addr  out  AW  slave-side address
- o_wb_data  out  DW  slave-side write data
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses
- i_wb_data  in  DW  slave read data
- o_owner  out  2  00 none, 01 A, 10 B (debug/LED)

Behaviour:
- Clock and reset: one clock i_clk. Asynchronous active-low reset i_rst_n: state=IDLE, last=B, timer=0. While in reset, all slave-side outputs, ack, err and o_owner are 0. o_a_stall and o_b_stall are 1.
- States:
  - IDLE: no owner.
  - OWN_A / OWN_B: a master owns the slave.
  - ABORT_A / ABORT_B: waiting for the aborted master to drop CYC.
- IDLE transitions (registered, 1-cycle grant latency):
  - A only: →OWN_A. B only: →OWN_B.
  - Both: grant the master ≠ last, and set last to the granted master.
  - Neither: stay.
- Owned state (OWN_x):
  - o_wb_cyc = i_x_cyc. o_wb_stb = i_x_stb.
  - we/addr/data muxed from master x.
  - o_x_stall = i_wb_stall, o_x_ack = i_wb_ack, o_x_err = i_wb_err, o_x_data = i_wb_data.
  - Combinational pass-through, zero added latency.
- Non-owner (including every master in IDLE): stall=1, ack=0, err=0.
  - o_a_data and o_b_data always carry i_wb_data.
  - Slave-side signals are 0 when not in OWN_x.
- Release: i_x_cyc low in OWN_x → o_wb_cyc drops the same cycle → IDLE next edge.
  - The other master, if requesting, is granted one cycle after IDLE is entered (i.e., from IDLE).
  - Minimum 1 dead cycle between owners.
- Timer:
  - In OWN_x it clears on any accepted strobe (stb & !stall), ack or err. Otherwise it increments while o_wb_cyc=1.
  - When timer = TIMEOUT: o_x_err=1 for exactly that cycle, o_wb_cyc/o_wb_stb forced 0 that cycle, next state ABORT_x.
  - In ABORT_x: slave side 0, o_x_stall=1, no ack. →IDLE when i_x_cyc=0.
  - Timer clears on entering IDLE.
- Boundary cases:
  - Slave ack and timeout in the same cycle: the ack wins (timer clears), no err.
  - Requester drops CYC while still waiting for grant: no grant issued.
  - Reset mid-cycle: immediate return to reset values; in-flight slave transaction is abandoned.
  - Master holds CYC continuously: it keeps ownership; fairness applies only at re-arbitration.
- o_owner: reflects OWN_x/ABORT_x as 01/10, 00 otherwise.

Test Plan:
- Reset, then A single write (addr 0x10, data 0xDEADBEEF) → o_owner=01 one cycle after cyc; o_wb_stb passes; ack returns to A only; B sees stall=1.
- A and B raise CYC on the same edge after reset → A granted first (last=B). A releases → 1 idle cycle → B granted. Repeat the simultaneous request → B then A alternation is verified.
- B owns and issues a 4-beat pipelined read of addr 0–3 with slave stall on beat 2 → o_b_stall mirrors it; 4 acks reach B with memdev data; A (requesting) waits until B's CYC falls.
- Slave never acks with TIMEOUT=8 → err pulses to the owner exactly 8 idle cycles after the last accepted stb; o_wb_cyc=0 from that cycle; ABORT held until the owner drops CYC; the other master is then granted.
- Ack coincident with the timeout cycle → no err; transaction completes normally.
- i_rst_n pulsed low asynchronously mid-transfer → outputs reach reset values without a clock edge; first request after release is granted normally.
